// File: rtl/median_pkg.sv
// Shared types and helpers for the streaming median filter.
//   state_t      : frame sequencer states (IDLE / RUN / FLUSH)
//   MAX_WINDOW   : largest supported window dimension
//   median_index : position of the median in a sorted ws*ws window
//   ws_legal     : window-size legality (odd, 3..MAX_WINDOW)
package median_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int MAX_WINDOW = 7;

  function automatic int median_index(input int ws);
    return ws * ws / 2;
  endfunction

  function automatic bit ws_legal(input int ws);
    return (ws % 2 == 1) && (ws >= 3) && (ws <= MAX_WINDOW);
  endfunction

endpackage

// File: rtl/stream_median_filter_if.sv
// Pixel stream bundle for the median filter: input stream (s_*) and
// output stream (m_*), each with valid/ready handshake.
//   master : pixel source / sink side (drives s_valid, s_data, m_ready)
//   slave  : filter side (drives s_ready, m_valid, m_data, m_last)
interface stream_median_filter_if #(
  parameter int PIX_W = 24
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/median_sorter.sv
// Single-channel combinational median of a WINDOW_SIZE x WINDOW_SIZE window.
//   win    : WINDOW_SIZE^2 samples, sample i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   median : element median_index(WINDOW_SIZE) of the sorted samples
// Odd-even transposition network: N rounds of compare-exchange fully sort N values.
module median_sorter
  import median_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int WINDOW_SIZE = 3
) (
  input  logic [WINDOW_SIZE*WINDOW_SIZE*DATA_WIDTH-1:0] win,
  output logic [DATA_WIDTH-1:0]                         median
);
  localparam int N   = WINDOW_SIZE * WINDOW_SIZE;
  localparam int MID = median_index(WINDOW_SIZE);

  logic [DATA_WIDTH-1:0] v [N];
  logic [DATA_WIDTH-1:0] t;

  always_comb begin
    t = '0;
    for (int i = 0; i < N; i++) v[i] = win[i*DATA_WIDTH +: DATA_WIDTH];
    for (int s = 0; s < N; s++) begin
      for (int i = s % 2; i + 1 < N; i += 2) begin
        if (v[i] > v[i+1]) begin
          t      = v[i];
          v[i]   = v[i+1];
          v[i+1] = t;
        end
      end
    end
    median = v[MID];
  end
endmodule

// File: rtl/stream_median_filter.sv
// Streaming 2-D median filter with line buffers, one output per input pixel.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a frame (IDLE only), latches cfg_width/cfg_height
//   cfg_width, cfg_height : frame size in pixels
//   pix (slave)           : s_valid/s_ready/s_data in, m_valid/m_ready/m_data/m_last out
//   busy                  : frame in progress
//   cfg_err               : sticky illegal-config flag, cleared by the next legal start
// Optional macro MEDIAN_PIPE_EN: register stage between window and sorters (latency 2).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting W*H input pixels
// FLUSH | pushing P*W+P zero beats to drain the window, then wait for last output
module stream_median_filter
  import median_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int WINDOW_SIZE  = 3,
  parameter int MAX_WIDTH    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           cfg_width,
  input  logic [15:0]           cfg_height,
  stream_median_filter_if.slave pix,
  output logic                  busy,
  output logic                  cfg_err
);
  localparam int WS    = WINDOW_SIZE;
  localparam int P     = WS / 2;
  localparam int PIX_W = NUM_CHANNELS * DATA_WIDTH;
  localparam int N     = WS * WS;
  localparam int AW    = $clog2(MAX_WIDTH);
  localparam logic [15:0] P16 = 16'(P);

  if (!ws_legal(WS)) begin : g_bad_window
    $error("stream_median_filter: WINDOW_SIZE must be odd and within 3..7");
  end

  state_t      state;
  logic [15:0] w_q, h_q, in_col, in_row, out_col, out_row, fill_left, flush_left;

  logic out_ready, front_ready, push, produce, pipe_empty, cfg_ok;
  logic tag_border, tag_last;
  logic sw_valid, sw_border, sw_last;
  logic [AW-1:0]    lb_addr;
  logic [PIX_W-1:0] in_pix, med_pix, result;

  logic [PIX_W-1:0] lb     [WS-1][MAX_WIDTH];
  logic [PIX_W-1:0] tap    [WS];
  logic [PIX_W-1:0] hist   [WS][WS-1];
  logic [PIX_W-1:0] win_nx [WS][WS];
  logic [PIX_W-1:0] sw     [WS][WS];

  assign out_ready = !pix.m_valid || pix.m_ready;
  assign push      = front_ready && ((state == RUN && pix.s_valid) ||
                                     (state == FLUSH && flush_left != 16'd0));
  assign pix.s_ready = (state == RUN) && front_ready;
  assign in_pix    = (state == RUN) ? pix.s_data : '0;
  assign produce   = (fill_left == 16'd0);
  assign lb_addr   = in_col[AW-1:0];
  assign cfg_ok    = cfg_width >= 16'(WS) && cfg_width <= 16'(MAX_WIDTH) &&
                     cfg_height >= 16'(WS);
  assign tag_border = out_row < P16 || out_row >= h_q - P16 ||
                      out_col < P16 || out_col >= w_q - P16;
  assign tag_last   = out_row == h_q - 16'd1 && out_col == w_q - 16'd1;

  // tap[i] is the pixel i rows above the incoming one; the new window column
  // puts the oldest row at the top.
  always_comb begin
    tap[0] = in_pix;
    for (int i = 1; i < WS; i++) tap[i] = lb[i-1][lb_addr];
    for (int i = 0; i < WS; i++) begin
      for (int j = 0; j < WS - 1; j++) win_nx[i][j] = hist[i][j];
      win_nx[i][WS-1] = tap[WS-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < WS - 1; i++) lb[i][lb_addr] <= tap[i];
      for (int i = 0; i < WS; i++)
        for (int j = 0; j < WS - 1; j++) hist[i][j] <= win_nx[i][j+1];
    end
  end

`ifdef MEDIAN_PIPE_EN
  logic             p_valid, p_border, p_last;
  logic [PIX_W-1:0] p_win [WS][WS];

  always_ff @(posedge clk) begin
    if (rst) p_valid <= 1'b0;
    else if (front_ready) p_valid <= push && produce;
  end

  always_ff @(posedge clk) begin
    if (push && produce) begin
      p_win    <= win_nx;
      p_border <= tag_border;
      p_last   <= tag_last;
    end
  end

  assign front_ready = !p_valid || out_ready;
  assign pipe_empty  = !p_valid;
  assign sw_valid    = p_valid;
  assign sw_border   = p_border;
  assign sw_last     = p_last;
  assign sw          = p_win;
`else
  assign front_ready = out_ready;
  assign pipe_empty  = 1'b1;
  assign sw_valid    = push && produce;
  assign sw_border   = tag_border;
  assign sw_last     = tag_last;
  assign sw          = win_nx;
`endif

  logic [N*DATA_WIDTH-1:0] sort_in  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   sort_out [NUM_CHANNELS];

  // Channel 0 occupies the pixel MSBs.
  always_comb begin
    med_pix = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      sort_in[ch] = '0;
      for (int i = 0; i < WS; i++)
        for (int j = 0; j < WS; j++)
          sort_in[ch][(i*WS+j)*DATA_WIDTH +: DATA_WIDTH] =
            sw[i][j][PIX_W-1-ch*DATA_WIDTH -: DATA_WIDTH];
      med_pix[PIX_W-1-ch*DATA_WIDTH -: DATA_WIDTH] = sort_out[ch];
    end
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_sort
    median_sorter #(.DATA_WIDTH(DATA_WIDTH), .WINDOW_SIZE(WS)) u_sorter (
      .win   (sort_in[ch]),
      .median(sort_out[ch])
    );
  end

  assign result = sw_border ? sw[P][P] : med_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix.m_valid <= 1'b0;
      pix.m_data  <= '0;
      pix.m_last  <= 1'b0;
    end else if (out_ready) begin
      pix.m_valid <= sw_valid;
      pix.m_last  <= sw_valid && sw_last;
      if (sw_valid) pix.m_data <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      w_q        <= '0;
      h_q        <= '0;
      in_col     <= '0;
      in_row     <= '0;
      out_col    <= '0;
      out_row    <= '0;
      fill_left  <= '0;
      flush_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w_q       <= cfg_width;
              h_q       <= cfg_height;
              busy      <= 1'b1;
              cfg_err   <= 1'b0;
              in_col    <= '0;
              in_row    <= '0;
              out_col   <= '0;
              out_row   <= '0;
              fill_left <= P16 * cfg_width + P16;
              state     <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push && in_col == w_q - 16'd1) begin
            if (in_row == h_q - 16'd1) begin
              flush_left <= P16 * w_q + P16;
              state      <= FLUSH;
            end else begin
              in_row <= in_row + 16'd1;
            end
          end
        end
        FLUSH: begin
          if (push) flush_left <= flush_left - 16'd1;
          if (flush_left == 16'd0 && pipe_empty && out_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        in_col <= (in_col == w_q - 16'd1) ? 16'd0 : in_col + 16'd1;
        if (fill_left != 16'd0) begin
          fill_left <= fill_left - 16'd1;
        end else begin
          out_col <= (out_col == w_q - 16'd1) ? 16'd0 : out_col + 16'd1;
          if (out_col == w_q - 16'd1)
            out_row <= (out_row == h_q - 16'd1) ? 16'd0 : out_row + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_stream_median_filter.sv
// Bench for stream_median_filter: a 3x3 and a 5x5 instance share stimulus,
// selected by sel. Outputs are compared with a sort-based reference model.
`timescale 1ns/1ps
module tb_stream_median_filter;
  localparam int PW = 24;
`ifdef MEDIAN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sel, start_c, s_valid_c, m_ready_c;
  logic [15:0]   cfg_w, cfg_h;
  logic [PW-1:0] s_data_c;
  logic          start3, start5, busy3, busy5, err3, err5;
  logic          s_ready, m_valid, m_last, busy, cfg_err;
  logic [PW-1:0] m_data;

  stream_median_filter_if #(.PIX_W(PW)) pix3 ();
  stream_median_filter_if #(.PIX_W(PW)) pix5 ();

  assign start3       = start_c && !sel;
  assign start5       = start_c && sel;
  assign pix3.s_valid = s_valid_c && !sel;
  assign pix5.s_valid = s_valid_c && sel;
  assign pix3.s_data  = s_data_c;
  assign pix5.s_data  = s_data_c;
  assign pix3.m_ready = m_ready_c && !sel;
  assign pix5.m_ready = m_ready_c && sel;

  assign s_ready = sel ? pix5.s_ready : pix3.s_ready;
  assign m_valid = sel ? pix5.m_valid : pix3.m_valid;
  assign m_data  = sel ? pix5.m_data  : pix3.m_data;
  assign m_last  = sel ? pix5.m_last  : pix3.m_last;
  assign busy    = sel ? busy5 : busy3;
  assign cfg_err = sel ? err5  : err3;

  stream_median_filter #(.DATA_WIDTH(8), .NUM_CHANNELS(3), .WINDOW_SIZE(3), .MAX_WIDTH(64)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .cfg_width(cfg_w), .cfg_height(cfg_h),
    .pix(pix3), .busy(busy3), .cfg_err(err3)
  );

  stream_median_filter #(.DATA_WIDTH(8), .NUM_CHANNELS(3), .WINDOW_SIZE(5), .MAX_WIDTH(64)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .cfg_width(cfg_w), .cfg_height(cfg_h),
    .pix(pix5), .busy(busy5), .cfg_err(err5)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [PW-1:0] img [0:4095];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Median of each channel over the ws x ws neighbourhood; border pixels pass through.
  function automatic logic [PW-1:0] ref_pix(input int k, input int w, input int h, input int ws);
    int r = k / w;
    int c = k % w;
    int p = ws / 2;
    int q[$];
    logic [PW-1:0] res = '0;
    logic [PW-1:0] px;
    if (r < p || r >= h - p || c < p || c >= w - p) return img[k];
    for (int ch = 0; ch < 3; ch++) begin
      q.delete();
      for (int dr = -p; dr <= p; dr++)
        for (int dc = -p; dc <= p; dc++) begin
          px = img[(r + dr) * w + c + dc];
          q.push_back(int'(px[23-8*ch -: 8]));
        end
      q.sort();
      res[23-8*ch -: 8] = 8'(q[q.size() / 2]);
    end
    return res;
  endfunction

  task automatic check_reset_vals(input string name);
    check_val({name, " s_ready"}, s_ready, 0);
    check_val({name, " m_valid"}, m_valid, 0);
    check_val({name, " m_data"},  m_data,  0);
    check_val({name, " m_last"},  m_last,  0);
    check_val({name, " busy"},    busy,    0);
    check_val({name, " cfg_err"}, cfg_err, 0);
  endtask

  task automatic try_bad_cfg(input int w, input int h, input string name);
    @(negedge clk);
    cfg_w = 16'(w); cfg_h = 16'(h); start_c = 1'b1; s_valid_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    #1;
    check_val({name, " cfg_err"}, cfg_err, 1);
    check_val({name, " busy"},    busy,    0);
    check_val({name, " s_ready"}, s_ready, 0);
    s_valid_c = 1'b0;
  endtask

  // rmode: 0 m_ready high, 1 m_ready toggling, 2 random valid gaps and m_ready.
  // abort_n > 0: assert rst once that many beats have been accepted.
  task automatic run_frame(input logic s, input int w, input int h, input int rmode,
                           input int abort_n, input string name);
    int ws = s ? 5 : 3;
    int fill = (ws / 2) * w + (ws / 2);
    int in_cnt = 0, out_cnt = 0, cyc = 0, acc_cyc = -1, mv_cyc = -1, extra = 0;
    bit tgl = 1'b1, acc_prev = 1'b0;
    sel = s;
    @(negedge clk);
    cfg_w = 16'(w); cfg_h = 16'(h); start_c = 1'b1; s_valid_c = 1'b0;
    @(negedge clk);
    start_c = 1'b0;
    #1;
    check_val({name, " busy_start"},    busy,    1);
    check_val({name, " cfg_err_start"}, cfg_err, 0);
    while (out_cnt < w * h && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (abort_n > 0 && in_cnt >= abort_n) break;
      case (rmode)
        0:       m_ready_c = 1'b1;
        1:       begin m_ready_c = tgl; tgl = !tgl; end
        default: m_ready_c = ($urandom_range(0, 2) != 0);
      endcase
      if (!s_valid_c || acc_prev)
        s_valid_c = (rmode != 2) || ($urandom_range(0, 3) != 0);
      s_data_c = (in_cnt < w * h) ? img[in_cnt] : 24'hABCDEF;
      #1;
      acc_prev = 1'b0;
      if (m_valid && mv_cyc < 0) mv_cyc = cyc;
      if (s_valid_c && s_ready) begin
        if (in_cnt == fill) acc_cyc = cyc;
        in_cnt++;
        acc_prev = 1'b1;
      end
      if (m_valid && m_ready_c) begin
        check_val($sformatf("%s px%0d", name, out_cnt), m_data, ref_pix(out_cnt, w, h, ws));
        check_val($sformatf("%s last%0d", name, out_cnt), m_last, out_cnt == w * h - 1);
        out_cnt++;
      end
    end
    if (abort_n > 0) begin
      s_valid_c = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_vals({name, " after_rst"});
    end else begin
      check_val({name, " out_count"}, out_cnt, w * h);
      check_val({name, " latency"}, mv_cyc - acc_cyc, LAT);
      @(negedge clk);
      s_valid_c = 1'b1;
      m_ready_c = 1'b1;
      #1;
      check_val({name, " busy_end"},    busy,    0);
      check_val({name, " m_valid_end"}, m_valid, 0);
      if (s_ready) extra++;
      repeat (3) begin
        @(negedge clk);
        #1;
        if (s_ready) extra++;
        if (m_valid) extra++;
      end
      s_valid_c = 1'b0;
      check_val({name, " in_count"}, in_cnt + extra, w * h);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; start_c = 1'b0; s_valid_c = 1'b0; m_ready_c = 1'b0;
    cfg_w = '0; cfg_h = '0; s_data_c = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset3");
    sel = 1'b1;
    #1;
    check_reset_vals("reset5");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) img[i] = 24'h102030;
    run_frame(1'b0, 5, 5, 0, 0, "flat");

    for (int i = 0; i < 25; i++) img[i] = 24'h0A0000;
    img[12] = 24'hFF0000;
    run_frame(1'b0, 5, 5, 0, 0, "impulse");

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) img[r * 8 + c] = {8'(r * 8 + c), 8'(c), 8'(r)};
    run_frame(1'b0, 8, 4, 1, 0, "ramp");

    try_bad_cfg(2, 5, "w2");
    try_bad_cfg(65, 4, "w65");
    try_bad_cfg(5, 2, "h2");
    for (int i = 0; i < 16; i++) img[i] = 24'($urandom);
    run_frame(1'b0, 4, 4, 2, 0, "w4h4");

    for (int i = 0; i < 192; i++) img[i] = 24'($urandom);
    run_frame(1'b0, 64, 3, 2, 0, "wmax");

    for (int i = 0; i < 25; i++) img[i] = 24'($urandom);
    run_frame(1'b0, 5, 5, 0, 10, "abort");
    for (int i = 0; i < 16; i++) img[i] = 24'($urandom);
    run_frame(1'b0, 4, 4, 2, 0, "post_abort");

    for (int i = 0; i < 54; i++) img[i] = 24'($urandom);
    run_frame(1'b0, 9, 6, 2, 0, "rand3");

    for (int i = 0; i < 49; i++)
      img[i] = {4'h0, 4'($urandom_range(0, 15)), 8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
    run_frame(1'b1, 7, 7, 2, 0, "rand5");

    for (int i = 0; i < 25; i++) img[i] = 24'($urandom);
    run_frame(1'b1, 5, 5, 0, 0, "min5");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_median_filter.md
Name: stream_median_filter

Overview:
Streaming 2-D median filter: one RGB/N-channel pixel per beat in raster order, valid/ready in and out, exactly one filtered pixel out per input pixel.
Successor to the frame-buffered median block. Uses WINDOW_SIZE-1 line buffers instead of whole-frame arrays, so storage scales with image width, not pixel count.
Sits between the pixel source (camera/DMA unpacker) and the downstream image-processing / output stage.

Parameters:
DATA_WIDTH, 8, bits per channel
NUM_CHANNELS, 3, channels per pixel; each is filtered independently
WINDOW_SIZE, 3, odd window dimension, legal range 3..7; P = WINDOW_SIZE/2
MAX_WIDTH, 1024, maximum line length; sets line-buffer depth

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse in IDLE: latch cfg, begin frame
cfg_width  in  16  image width in pixels
cfg_height  in  16  image height in pixels
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_data  in  NUM_CHANNELS*DATA_WIDTH  pixel; channel 0 is the MSBs (red)
m_valid  out  1  output beat valid
m_ready  in  1  downstream accept
m_data  out  NUM_CHANNELS*DATA_WIDTH  filtered pixel
m_last  out  1  high with final pixel of the frame
busy  out  1  frame in progress
cfg_err  out  1  sticky illegal-config flag; cleared by the next start

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, cfg_err=0; FSM enters IDLE; all counters are 0. Line-buffer contents are don't-care.
- Reset mid-frame aborts the frame immediately. The next frame needs a new start.
- FSM states: IDLE -> RUN -> FLUSH -> IDLE.
- IDLE, start=1:
  - Config is legal if WINDOW_SIZE <= W <= MAX_WIDTH and H >= WINDOW_SIZE.
  - Legal: latch W and H, set busy=1, cfg_err=0, go to RUN.
  - Illegal: cfg_err=1, stay in IDLE.
  - start outside IDLE is ignored.
- RUN:
  - s_ready = (!m_valid || m_ready).
  - Each accepted beat pushes the pixel through the line buffers and the WxW window shift register, and increments the input index.
  - After W*H accepted beats, go to FLUSH.
- FLUSH:
  - s_ready=0.
  - Internally generates P*W+P dummy beats (value 0), each advancing only when the output stage can accept.
  - Go to IDLE after the last output is accepted; busy then drops.
- Output index k (raster, row r=k/W, column c=k%W) is produced by the beat that brings input index k+P*W+P into the window.
  - Beats with input index < P*W+P produce no output (pipeline fill).
  - Latency: m_valid rises the cycle after that beat.
- Interior pixels (P <= r < H-P and P <= c < W-P): each channel outputs element (WINDOW_SIZE^2)/2 of the sorted window values for that channel.
- Border pixels (within P of any edge): output equals the unmodified centre pixel. Window columns that wrap across line ends are never used.
- Output register holds m_data, m_valid and m_last stable while m_valid && !m_ready. No beat is lost or duplicated.
- m_last is asserted only on output index W*H-1.
- Row and column counters are 16-bit and wrap at W-1 and H-1.

Optional Feature:
MEDIAN_PIPE_EN
- Defined:
  - Inserts a register stage between the window and the sorting network, so latency is 2 cycles instead of 1.
  - The stage is a valid-tagged register with the same stall rule as the output register; backpressure still loses no data.
  - Border-select and m_last tags travel with it.
- Undefined: sorter is combinational into the output register (1-cycle latency).

Decomposition:
- Package median_pkg:
  - state enum (IDLE/RUN/FLUSH)
  - MAX_WINDOW=7
  - function median_index(ws) = ws*ws/2
  - parameter legality checks (odd WINDOW_SIZE, range 3..7) as elaboration asserts
- Sub-module median_sorter #(DATA_WIDTH, WINDOW_SIZE): one channel, WINDOW_SIZE^2 inputs, combinational median via compare-exchange network. Instantiated NUM_CHANNELS times.

Test Plan:
- 3x3, W=5 H=5, all pixels 0x102030 -> 25 outputs, all 0x102030; m_last on beat 25; busy drops after.
- 3x3, W=5 H=5, all red=10 except single impulse red=255 at (2,2) -> output (2,2) red=10; all others unchanged.
- 3x3, W=8 H=4, ramp red=r*8+c, m_ready toggling 1/0 every cycle -> interior outputs equal centre ramp value; exactly 32 beats; no drop or duplicate.
- start with W=2 -> cfg_err=1, busy=0, s_ready=0. Then start with W=4 H=4 -> cfg_err=0, normal frame.
- rst asserted after 10 input beats -> next cycle all outputs at reset values. New 4x4 frame then completes correctly with 16 outputs.
- 5x5 window, W=H=7, random data, checked against a reference model. With MEDIAN_PIPE_EN the first m_valid is exactly 1 cycle later than without.
